// File: rtl/julia_iteration_controller.sv
// rtl/julia_iteration_controller.sv - sequences one Julia/Mandelbrot pixel job through the z-update datapath
module julia_iteration_controller #(
   parameter int               WIDTH         = 22,
   parameter int               MAX_ITER      = 255,
   parameter logic [WIDTH-1:0] ESCAPE_THRESH = 22'h002000,
   parameter int               TAG_W         = 19
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_z_real,
   input  logic [WIDTH-1:0] in_z_imag,
   input  logic [WIDTH-1:0] in_c_real,
   input  logic [WIDTH-1:0] in_c_imag,
   input  logic [TAG_W-1:0] in_tag,
   output logic [WIDTH-1:0] calc_z_real,
   output logic [WIDTH-1:0] calc_z_imag,
   output logic [WIDTH-1:0] calc_c_real,
   output logic [WIDTH-1:0] calc_c_imag,
   input  logic [WIDTH-1:0] calc_z_real_next,
   input  logic [WIDTH-1:0] calc_z_imag_next,
   input  logic [WIDTH-1:0] calc_size_sq,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_iter,
   output logic             out_escaped,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ITERATE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam logic [7:0] ITER_CAP = 8'(MAX_ITER);

   logic [1:0] state;
   logic [7:0] count;
   logic [7:0] count_inc;
   logic       esc;
   logic       accept;

   // Handshake and termination terms; a negative |z|^2 (wrapped) never escapes.
   always_comb begin
      in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
      accept    = in_valid && in_ready;
      count_inc = count + 8'd1;
      esc       = $signed(calc_size_sq) >= $signed(ESCAPE_THRESH);
      out_valid = (state == ST_DONE);
      busy      = (state != ST_IDLE);
   end

   // Job sequencing: accept (also straight out of DONE), iterate, hold result.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state       <= ST_IDLE;
         count       <= 8'd0;
         calc_z_real <= '0;
         calc_z_imag <= '0;
         calc_c_real <= '0;
         calc_c_imag <= '0;
         out_iter    <= 8'd0;
         out_escaped <= 1'b0;
         out_tag     <= '0;
      end else if (accept) begin
         calc_z_real <= in_z_real;
         calc_z_imag <= in_z_imag;
         calc_c_real <= in_c_real;
         calc_c_imag <= in_c_imag;
         out_tag     <= in_tag;
         count       <= 8'd0;
         state       <= ST_ITERATE;
      end else begin
         case (state)
            ST_ITERATE: begin
               calc_z_real <= calc_z_real_next;
               calc_z_imag <= calc_z_imag_next;
               count       <= count_inc;
               if (esc || (count_inc == ITER_CAP)) begin
                  out_iter    <= count_inc;
                  out_escaped <= esc;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_julia_iteration_controller.sv
// tb/tb_julia_iteration_controller.sv - self-checking bench for julia_iteration_controller
module tb_julia_iteration_controller;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] in_z_real, in_z_imag, in_c_real, in_c_imag;
   logic [18:0] in_tag;
   logic [21:0] calc_z_real, calc_z_imag, calc_c_real, calc_c_imag;
   logic [21:0] calc_z_real_next, calc_z_imag_next, calc_size_sq;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_iter;
   logic        out_escaped;
   logic [18:0] out_tag;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   julia_iteration_controller dut (
      .clk(clk), .n_rst(n_rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_z_real(in_z_real), .in_z_imag(in_z_imag),
      .in_c_real(in_c_real), .in_c_imag(in_c_imag), .in_tag(in_tag),
      .calc_z_real(calc_z_real), .calc_z_imag(calc_z_imag),
      .calc_c_real(calc_c_real), .calc_c_imag(calc_c_imag),
      .calc_z_real_next(calc_z_real_next), .calc_z_imag_next(calc_z_imag_next),
      .calc_size_sq(calc_size_sq),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_iter(out_iter), .out_escaped(out_escaped), .out_tag(out_tag),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Q11.11 complex arithmetic, wrapping to 22 bits
   function automatic logic [21:0] f_nr(input logic signed [21:0] zr, input logic signed [21:0] zi,
                                        input logic signed [21:0] cr);
      longint a = zr;
      longint b = zi;
      longint c = cr;
      return 22'(((a * a - b * b) >>> 11) + c);
   endfunction

   function automatic logic [21:0] f_ni(input logic signed [21:0] zr, input logic signed [21:0] zi,
                                        input logic signed [21:0] ci);
      longint a = zr;
      longint b = zi;
      longint c = ci;
      return 22'(((2 * a * b) >>> 11) + c);
   endfunction

   function automatic logic [21:0] f_sz(input logic signed [21:0] zr, input logic signed [21:0] zi);
      longint a = zr;
      longint b = zi;
      return 22'((a * a + b * b) >>> 11);
   endfunction

   // Combinational datapath stand-in
   always_comb begin
      calc_z_real_next = f_nr(calc_z_real, calc_z_imag, calc_c_real);
      calc_z_imag_next = f_ni(calc_z_real, calc_z_imag, calc_c_imag);
      calc_size_sq     = f_sz(calc_z_real_next, calc_z_imag_next);
   end

   // Reference: iterate z <- z^2 + c until |z|^2 >= 4.0 or 255 iterations
   function automatic void ref_job(input logic [21:0] zr0, input logic [21:0] zi0,
                                   input logic [21:0] cr, input logic [21:0] ci,
                                   output int n, output bit e);
      logic signed [21:0] zr, zi, nr, ni, sz;
      zr = zr0;
      zi = zi0;
      n = 255;
      e = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         nr = f_nr(zr, zi, cr);
         ni = f_ni(zr, zi, ci);
         sz = f_sz(nr, ni);
         if (sz >= 22'sh002000) begin
            n = k;
            e = 1'b1;
            return;
         end
         zr = nr;
         zi = ni;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a job, wait for its result (edges counted including the accept edge), consume it
   task automatic run_job(input logic [21:0] zr, input logic [21:0] zi, input logic [21:0] cr,
                          input logic [21:0] ci, input logic [18:0] tag,
                          output int iter, output bit esc, output int lat, output logic [18:0] tago);
      int guard = 0;
      out_ready = 1'b1;
      while (!in_ready && guard < 600) begin
         tick();
         guard++;
      end
      in_z_real = zr; in_z_imag = zi; in_c_real = cr; in_c_imag = ci; in_tag = tag;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 600) begin
         tick();
         lat++;
      end
      iter = out_iter;
      esc = out_escaped;
      tago = out_tag;
      tick();
   endtask

   task automatic test_reset();
      n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_z_real = '0; in_z_imag = '0; in_c_real = '0; in_c_imag = '0; in_tag = '0;
      tick();
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b exp 0", busy); end
      vectors++; if ({out_iter, out_escaped, out_tag} !== 28'd0) begin miscompares++; $display("FAIL rst_outputs got %h exp 0", {out_iter, out_escaped, out_tag}); end
      vectors++; if ({calc_z_real, calc_z_imag, calc_c_real, calc_c_imag} !== 88'd0) begin miscompares++; $display("FAIL rst_calc got %h exp 0", {calc_z_real, calc_z_imag, calc_c_real, calc_c_imag}); end
      n_rst = 1'b1;
      tick();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
   endtask

   task automatic test_directed();
      int it, lat; bit e; logic [18:0] t;
      run_job(22'h0, 22'h0, 22'h0, 22'h0, 19'h00011, it, e, lat, t);
      vectors++; if (it !== 255 || e !== 1'b0) begin miscompares++; $display("FAIL cap_result got %0d/%0b exp 255/0", it, e); end
      vectors++; if (lat !== 256) begin miscompares++; $display("FAIL cap_latency got %0d exp 256", lat); end
      vectors++; if (t !== 19'h00011) begin miscompares++; $display("FAIL cap_tag got %h exp 00011", t); end
      run_job(22'h0, 22'h0, 22'h001000, 22'h0, 19'h00022, it, e, lat, t);
      vectors++; if (it !== 1 || e !== 1'b1) begin miscompares++; $display("FAIL two_result got %0d/%0b exp 1/1", it, e); end
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL two_latency got %0d exp 2", lat); end
      run_job(22'h0, 22'h0, 22'h000800, 22'h0, 19'h00033, it, e, lat, t);
      vectors++; if (it !== 2 || e !== 1'b1) begin miscompares++; $display("FAIL one_result got %0d/%0b exp 2/1", it, e); end
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL one_latency got %0d exp 3", lat); end
      run_job(22'h0, 22'h0, 22'h3FF000, 22'h0, 19'h00044, it, e, lat, t);
      vectors++; if (it !== 1 || e !== 1'b1) begin miscompares++; $display("FAIL neg_two_result got %0d/%0b exp 1/1", it, e); end
   endtask

   task automatic test_random();
      int it, lat, ref_n; bit e, ref_e; logic [18:0] t, tag;
      logic [21:0] zr, zi, cr, ci;
      for (int j = 0; j < 16; j++) begin
         zr  = 22'($signed($urandom_range(0, 2048)) - 1024);
         zi  = 22'($signed($urandom_range(0, 2048)) - 1024);
         cr  = 22'($signed($urandom_range(0, 10240)) - 5120);
         ci  = 22'($signed($urandom_range(0, 6144)) - 3072);
         tag = 19'($urandom);
         ref_job(zr, zi, cr, ci, ref_n, ref_e);
         run_job(zr, zi, cr, ci, tag, it, e, lat, t);
         vectors++; if (it !== ref_n || e !== ref_e) begin miscompares++; $display("FAIL rand_result[%0d] got %0d/%0b exp %0d/%0b", j, it, e, ref_n, ref_e); end
         vectors++; if (lat !== ref_n + 1) begin miscompares++; $display("FAIL rand_latency[%0d] got %0d exp %0d", j, lat, ref_n + 1); end
         vectors++; if (t !== tag) begin miscompares++; $display("FAIL rand_tag[%0d] got %h exp %h", j, t, tag); end
      end
   endtask

   task automatic test_backpressure();
      int guard = 0;
      int xfers = 0;
      out_ready = 1'b0;
      in_z_real = '0; in_z_imag = '0; in_c_real = 22'h000800; in_c_imag = '0; in_tag = 19'h00055;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (!out_valid && guard < 600) begin tick(); guard++; end
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         vectors++; if (out_valid !== 1'b1 || out_iter !== 8'd2 || out_tag !== 19'h00055) begin miscompares++; $display("FAIL bp_hold[%0d] got %0b/%0d/%h exp 1/2/00055", k, out_valid, out_iter, out_tag); end
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %0b exp 0", k, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (out_valid && out_ready) xfers++;
         tick();
      end
      vectors++; if (xfers !== 1) begin miscompares++; $display("FAIL bp_transfers got %0d exp 1", xfers); end
   endtask

   task automatic test_back_to_back();
      int guard = 0;
      out_ready = 1'b1;
      in_z_real = '0; in_z_imag = '0; in_c_real = 22'h001000; in_c_imag = '0; in_tag = 19'h00066;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (!out_valid && guard < 600) begin tick(); guard++; end
      vectors++; if (out_iter !== 8'd1 || out_tag !== 19'h00066) begin miscompares++; $display("FAIL b2b_first got %0d/%h exp 1/00066", out_iter, out_tag); end
      in_c_real = 22'h000800; in_tag = 19'h00042;
      in_valid = 1'b1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got %0b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      vectors++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_iterate got busy=%0b valid=%0b ready=%0b exp 1/0/0", busy, out_valid, in_ready); end
      guard = 0;
      while (!out_valid && guard < 600) begin tick(); guard++; end
      vectors++; if (out_iter !== 8'd2 || out_escaped !== 1'b1 || out_tag !== 19'h00042) begin miscompares++; $display("FAIL b2b_second got %0d/%0b/%h exp 2/1/00042", out_iter, out_escaped, out_tag); end
      tick();
   endtask

   task automatic test_reset_mid();
      int it, lat; bit e; logic [18:0] t;
      out_ready = 1'b1;
      in_z_real = '0; in_z_imag = '0; in_c_real = '0; in_c_imag = '0; in_tag = 19'h00077;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst got valid=%0b busy=%0b ready=%0b exp 0/0/1", out_valid, busy, in_ready); end
      run_job(22'h0, 22'h0, 22'h001000, 22'h0, 19'h00088, it, e, lat, t);
      vectors++; if (it !== 1 || e !== 1'b1 || t !== 19'h00088) begin miscompares++; $display("FAIL midrst_job got %0d/%0b/%h exp 1/1/00088", it, e, t); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/julia_iteration_controller.md
# julia_iteration_controller

Sequences one Julia/Mandelbrot pixel job through the combinational z-update datapath (z ← z² + c, Q11.11 signed fixed point). It accepts a job on a valid/ready input, registers z, and feeds the datapath one iteration per clock. It stops on escape or on the iteration cap and returns the escape count on a valid/ready output. It sits between the pixel-address generator and the colour-mapping stage.

## Interface
Parameters:
- WIDTH, 22, fixed-point word width (11 integral, 11 fractional bits)
- MAX_ITER, 255, iteration cap (1..255)
- ESCAPE_THRESH, 22'h002000, escape limit on |z|² (4.0 in Q11.11), signed compare
- TAG_W, 19, width of the pass-through pixel tag

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  reset, synchronous, active-low
- in_valid  in  1  job offered
- in_ready  out  1  job can be accepted this cycle (combinational from state and out_ready)
- in_z_real, in_z_imag  in  WIDTH  initial z0, signed
- in_c_real, in_c_imag  in  WIDTH  constant c, signed
- in_tag  in  TAG_W  pixel identifier
- calc_z_real, calc_z_imag  out  WIDTH  current z driven to the datapath
- calc_c_real, calc_c_imag  out  WIDTH  c driven to the datapath
- calc_z_real_next, calc_z_imag_next  in  WIDTH  datapath z² + c
- calc_size_sq  in  WIDTH  datapath |z_next|², signed
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_iter  out  8  iteration count at termination
- out_escaped  out  1  1 = escaped, 0 = hit MAX_ITER
- out_tag  out  TAG_W  tag of the job
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ITERATE, DONE.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Accept (in_valid & in_ready): latch z0 into z registers, c and tag into registers, count ← 0, go to ITERATE.
- ITERATE, every cycle:
  - z ← calc_*_next; count ← count + 1.
  - esc = ($signed(calc_size_sq) >= ESCAPE_THRESH).
  - If esc or count + 1 == MAX_ITER: out_iter ← count + 1, out_escaped ← esc, go to DONE.
  - Otherwise stay in ITERATE.
- The controller uses its own count. The datapath's iteration output is unused, so c = 0 still terminates at MAX_ITER.
- DONE: out_valid = 1, and out_iter, out_escaped and out_tag are stable.
  - out_ready & in_valid: accept the new job in the same cycle and go to ITERATE.
  - out_ready & !in_valid: go to IDLE.
  - !out_ready: hold.
- Escape on the final allowed iteration reports out_escaped = 1 with out_iter = MAX_ITER.
- calc_* outputs are driven from registers. Their values in IDLE are don't-care and are held at their last value.
- Arithmetic overflow wraps inside the datapath. The controller does not saturate. A negative calc_size_sq counts as not escaped.

## Timing
- Reset (n_rst low at a clock edge): state ← IDLE, every registered output ← 0 (out_valid, out_iter, out_escaped, out_tag, calc_*), busy = 0. in_ready = 1 in the first cycle after reset release.
- Reset asserted mid-ITERATE or mid-DONE: the job is discarded; out_valid is 0 after that edge.
- Latency from the accept edge to out_valid high is N + 1 edges, where N = out_iter. Minimum is 2 edges (escape on iteration 1).
- Throughput with out_ready held high is one job per N + 1 cycles. No idle bubble between jobs.
- in_valid while in ITERATE is ignored; in_ready = 0.

## Test plan
- z0 = 0, c = 0 → no escape: out_iter = 255, out_escaped = 0, out_valid 256 edges after accept.
- z0 = 0, c = (0x001000, 0) (2.0) → z1 = 2.0, |z|² = 4.0: out_iter = 1, out_escaped = 1, latency 2.
- z0 = 0, c = (0x000800, 0) (1.0) → z = 1, then 2: out_iter = 2, out_escaped = 1. Then c = (0x3FF000, 0) (−2.0) → out_iter = 1, out_escaped = 1.
- Backpressure: 1.0 job finishes while out_ready = 0 for 5 cycles → out_valid, out_iter = 2 and out_tag stable; in_ready = 0; release → one transfer only.
- Back-to-back: in DONE, out_ready = 1 and in_valid = 1 with tag 0x00042 → result consumed and new job accepted on the same edge; next cycle busy = 1 and state is ITERATE.
- Reset low for one edge while in ITERATE (c = 0) → next cycle out_valid = 0, busy = 0, in_ready = 1. A following 2.0 job returns out_iter = 1.
